// File: rtl/subtractor_serial.sv
// subtractor_serial: bit-serial two's-complement subtractor, Z = X - Y,
// one bit per clock, LSB first, under a start/done handshake.
// Status flags on completion: sign, zero, borrow, parity (even), overflow.
// Optional build macro SUBTRACTOR_SERIAL_ADD_EN adds an add_sub input
// (1 = add); in add mode the borrow output reports carry-out.
module subtractor_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
`ifdef SUBTRACTOR_SERIAL_ADD_EN
  input  logic             add_sub,
`endif
  output logic [WIDTH-1:0] Z,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic             zero,
  output logic             borrow,
  output logic             parity,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic             xm_q, xm_d;
  logic             ym_q, ym_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             borrow_q, borrow_d;
  logic             parity_q, parity_d;
  logic             ovf_q, ovf_d;

  // Operation mode captured with the operands; constant subtract otherwise.
  logic             op_add;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
  logic             add_q, add_d;
  assign op_add = add_q;
`else
  assign op_add = 1'b0;
`endif

  // Single-bit cell: difference/sum bit and borrow/carry out of the LSB pair.
  logic             bit_a, bit_b, bit_d, bit_cout;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;
  logic             zm;

  assign bit_a    = xs_q[0];
  assign bit_b    = ys_q[0];
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign res_nxt  = {bit_d, res_q[WIDTH-1:1]};
  assign zm       = res_nxt[WIDTH-1];

  // Full subtractor (or full adder in add mode) on the current bit pair.
  always_comb begin
    bit_d    = bit_a ^ bit_b ^ bin_q;
    bit_cout = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bin_q);
    if (op_add)
      bit_cout = (bit_a & bit_b) | (bin_q & (bit_a ^ bit_b));
  end

  // Next-state logic: accept in IDLE/DONE, shift one bit per RUN cycle,
  // publish result and flags on the edge that processes the MSB.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    res_d    = res_q;
    bin_d    = bin_q;
    xm_d     = xm_q;
    ym_d     = ym_q;
    z_d      = z_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    borrow_d = borrow_q;
    parity_d = parity_q;
    ovf_d    = ovf_q;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
    add_d    = add_q;
`endif
    case (state_q)
      S_RUN: begin
        res_d = res_nxt;
        xs_d  = {1'b0, xs_q[WIDTH-1:1]};
        ys_d  = {1'b0, ys_q[WIDTH-1:1]};
        bin_d = bit_cout;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d  = S_DONE;
          z_d      = res_nxt;
          sign_d   = zm;
          zero_d   = (res_nxt == '0);
          parity_d = ~(^res_nxt);
          borrow_d = bit_cout;
          if (op_add)
            ovf_d = (xm_q & ym_q & ~zm) | (~xm_q & ~ym_q & zm);
          else
            ovf_d = (xm_q & ~ym_q & ~zm) | (~xm_q & ym_q & zm);
        end
      end
      default: begin
        // IDLE, DONE and the unused encoding all behave as "ready".
        if (start) begin
          state_d = S_RUN;
          xs_d    = X;
          ys_d    = Y;
          xm_d    = X[WIDTH-1];
          ym_d    = Y[WIDTH-1];
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
          add_d   = add_sub;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State, datapath and result registers; reset discards any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      xs_q     <= '0;
      ys_q     <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      xm_q     <= 1'b0;
      ym_q     <= 1'b0;
      z_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      borrow_q <= 1'b0;
      parity_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
      add_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      xm_q     <= xm_d;
      ym_q     <= ym_d;
      z_q      <= z_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      borrow_q <= borrow_d;
      parity_q <= parity_d;
      ovf_q    <= ovf_d;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
      add_q    <= add_d;
`endif
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign Z        = z_q;
  assign sign     = sign_q;
  assign zero     = zero_q;
  assign borrow   = borrow_q;
  assign parity   = parity_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Scoreboard bench for subtractor_serial: stimulus pushes expected results
// computed with plain integer arithmetic; a negedge monitor pops on done.
module tb_subtractor_serial;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] X, Y, Z;
  logic         busy, done, sign, zero, borrow, parity, overflow;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
  logic         add_sub;
`endif

  subtractor_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
`ifdef SUBTRACTOR_SERIAL_ADD_EN
    .add_sub(add_sub),
`endif
    .Z(Z), .busy(busy), .done(done), .sign(sign), .zero(zero),
    .borrow(borrow), .parity(parity), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] z;
    logic         sign, zero, borrow, parity, ovf;
    int unsigned  cyc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic add, input int unsigned c);
    exp_t   e;
    longint ux, uy, sx, sy, r, sr, m;
    m  = longint'(1) << W;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[W-1] ? ux - m : ux;
    sy = y[W-1] ? uy - m : uy;
    if (add) begin
      r  = ux + uy;
      sr = sx + sy;
      e.borrow = (r >= m);
    end else begin
      r  = ux - uy;
      sr = sx - sy;
      e.borrow = (ux < uy);
    end
    r = ((r % m) + m) % m;
    e.z      = W'(r);
    e.sign   = (r >= (m / 2));
    e.zero   = (r == 0);
    e.parity = ($countones(e.z) % 2 == 0);
    e.ovf    = (sr >= (m / 2)) || (sr < -(m / 2));
    e.cyc    = c;
    return e;
  endfunction

  // Monitor: compare each done pulse with the oldest expectation; also
  // check that Z holds while busy.
  logic [W-1:0] prev_z = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && busy) chk("z_hold_busy", Z, prev_z);
      if (!rst && done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("Z", Z, e.z);
          chk("sign", sign, e.sign);
          chk("zero", zero, e.zero);
          chk("borrow", borrow, e.borrow);
          chk("parity", parity, e.parity);
          chk("overflow", overflow, e.ovf);
          chk("done_cycle", cyc, e.cyc);
        end
      end
      prev_z = Z;
    end
  end

  // Issue one operation from a negedge; returns at the negedge where done is
  // high, so an immediate next call exercises back-to-back accept.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic add, input bit mid_pulse);
    int n;
    start = 1'b1; X = x; Y = y;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
    add_sub = add;
`endif
    q.push_back(model(x, y, add, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    n = 1;
    if (mid_pulse) begin
      repeat (4) @(negedge clk);
      start = 1'b1; X = ~x; Y = x ^ 16'h5A5A;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
      add_sub = ~add;
`endif
      @(negedge clk);
      start = 1'b0;
      n = 6;
    end
    while (busy && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("busy_timeout", 1, 0);
      $display("FAIL busy_timeout: operation never completed");
      $fatal(1, "timeout");
    end
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    logic         ra;
    rst = 1'b1; start = 1'b0; X = '0; Y = '0;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
    add_sub = 1'b0;
`endif
    #3;
    chk("rst_Z", Z, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {sign, zero, borrow, parity, overflow}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_op(16'h0005, 16'h0003, 1'b0, 1'b0); @(negedge clk);
    run_op(16'h0003, 16'h0005, 1'b0, 1'b0); @(negedge clk);
    run_op(16'h1234, 16'h1234, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0); @(negedge clk);
    run_op(16'h0100, 16'h0F00, 1'b0, 1'b1); @(negedge clk);

    // Abort mid-run: reset asynchronously, no done may follow.
    start = 1'b1; X = 16'h4321; Y = 16'h0123;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_Z", Z, 0);
    chk("abort_flags", {sign, zero, borrow, parity, overflow}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0); @(negedge clk);

`ifdef SUBTRACTOR_SERIAL_ADD_EN
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0); @(negedge clk);
    run_op(16'h7FFF, 16'h0001, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0); @(negedge clk);
`endif

    for (int i = 0; i < 40; i++) begin
      rx = W'($urandom);
      ry = (i % 7 == 0) ? rx : W'($urandom);
      ra = 1'b0;
`ifdef SUBTRACTOR_SERIAL_ADD_EN
      ra = 1'($urandom);
`endif
      run_op(rx, ry, ra, 1'b0);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
